// File: rtl/riscv_dmem_arbiter_if.sv
// Bundle of both requester ports and the memory port of the data-memory arbiter.
// slave = arbiter side, master = the requesters/memory that surround it.
interface riscv_dmem_arbiter_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MSIZE_WIDTH = 3
);
    logic                   m0_req_i;
    logic                   m0_we_i;
    logic [ADDR_WIDTH-1:0]  m0_addr_i;
    logic [DATA_WIDTH-1:0]  m0_wdata_i;
    logic [MSIZE_WIDTH-1:0] m0_size_i;
    logic                   m0_gnt_o;
    logic                   m0_rvalid_o;
    logic [DATA_WIDTH-1:0]  m0_rdata_o;
    logic                   m0_err_o;

    logic                   m1_req_i;
    logic                   m1_we_i;
    logic [ADDR_WIDTH-1:0]  m1_addr_i;
    logic [DATA_WIDTH-1:0]  m1_wdata_i;
    logic [MSIZE_WIDTH-1:0] m1_size_i;
    logic                   m1_gnt_o;
    logic                   m1_rvalid_o;
    logic [DATA_WIDTH-1:0]  m1_rdata_o;
    logic                   m1_err_o;

    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [ADDR_WIDTH-1:0]  mem_addr_o;
    logic [DATA_WIDTH-1:0]  mem_wdata_o;
    logic [MSIZE_WIDTH-1:0] mem_size_o;
    logic                   mem_gnt_i;
    logic                   mem_rvalid_i;
    logic [DATA_WIDTH-1:0]  mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_size_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_size_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_size_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_size_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o
    );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Round-robin arbiter/sequencer for LSU (m0) and debug/DMA (m1) onto one data-memory port.
// Latency: grant comb in IDLE, mem_req_o next cycle, response comb with mem_rvalid_i; errors answer 1 cycle after grant.
// Backpressure: one transaction outstanding; mem_gnt_i stalls hold the request, no new grant until back in IDLE.
module riscv_dmem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MSIZE_WIDTH = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    riscv_dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RESP,
        ARB_ERR
    } arb_state_e;

    arb_state_e             state_q, state_d;
    logic                   owner_q;
    logic                   prio_q;
    logic                   mem_we_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;
    logic [MSIZE_WIDTH-1:0] mem_size_q;

    logic                   win;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [MSIZE_WIDTH-1:0] sel_size;
    logic                   sel_mis;

    logic                   grant;
    logic                   done;
    logic                   mem_req;
    logic                   rsp_vld;
    logic                   rsp_err;
    logic [DATA_WIDTH-1:0]  rsp_dat;

    // Bit 2 of the size code only marks unsigned loads; codes 3, 6 and 7 have no valid meaning.
    function automatic logic is_misaligned(input logic [MSIZE_WIDTH-1:0] size,
                                           input logic [1:0]             addr_lo);
        logic mis;
        case (size)
            MSIZE_WIDTH'(0), MSIZE_WIDTH'(4): mis = 1'b0;
            MSIZE_WIDTH'(1), MSIZE_WIDTH'(5): mis = addr_lo[0];
            MSIZE_WIDTH'(2):                  mis = (addr_lo != 2'b00);
            default:                          mis = 1'b1;
        endcase
        return mis;
    endfunction

    always_comb begin
        win       = (bus.m0_req_i && bus.m1_req_i) ? prio_q : bus.m1_req_i;
        sel_we    = win ? bus.m1_we_i    : bus.m0_we_i;
        sel_addr  = win ? bus.m1_addr_i  : bus.m0_addr_i;
        sel_wdata = win ? bus.m1_wdata_i : bus.m0_wdata_i;
        sel_size  = win ? bus.m1_size_i  : bus.m0_size_i;
        sel_mis   = is_misaligned(sel_size, sel_addr[1:0]);
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        rsp_vld = 1'b0;
        rsp_err = 1'b0;
        rsp_dat = '0;
        case (state_q)
            ARB_IDLE: begin
                if ((bus.m0_req_i || bus.m1_req_i) && !rst_i) begin
                    grant   = 1'b1;
                    state_d = sel_mis ? ARB_ERR : ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                mem_req = 1'b1;
                if (bus.mem_gnt_i) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                // Reset abandons the transaction silently, even if the data arrives that cycle.
                if (bus.mem_rvalid_i && !rst_i) begin
                    rsp_vld = 1'b1;
                    rsp_dat = bus.mem_rdata_i;
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_ERR: begin
                rsp_vld = !rst_i;
                rsp_err = !rst_i;
                done    = 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= win;
            end
            // Misaligned requests never reach the memory bus, so its fields stay put.
            if (grant && !sel_mis) begin
                mem_we_q    <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                mem_size_q  <= sel_size;
            end
            if (done) begin
                prio_q <= ~owner_q;
            end
        end
    end

    assign bus.m0_gnt_o    = grant & ~win;
    assign bus.m1_gnt_o    = grant & win;
    assign bus.m0_rvalid_o = rsp_vld & ~owner_q;
    assign bus.m1_rvalid_o = rsp_vld & owner_q;
    assign bus.m0_err_o    = rsp_err & ~owner_q;
    assign bus.m1_err_o    = rsp_err & owner_q;
    assign bus.m0_rdata_o  = owner_q ? '0 : rsp_dat;
    assign bus.m1_rdata_o  = owner_q ? rsp_dat : '0;

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_size_o  = mem_size_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed and randomized bench for riscv_dmem_arbiter against a transaction-level model.
module tb_riscv_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSIZE_WIDTH(SW)) bus ();
    riscv_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MSIZE_WIDTH(SW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one transaction in flight; rr names who wins a tie.
    bit outst, accepted, mis, own, rr;
    logic          we_m;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] wdata_m;
    logic [SW-1:0] size_m;
    bit last_g0, last_g1;
    int obs_rsp;
    int gnt_log[$];

    // Memory responder.
    bit pend, gave_gnt;
    int dly, gnt_pct, max_dly, spur_pct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_mis(input logic [SW-1:0] s, input logic [AW-1:0] a);
        int unsigned nb;
        if (s == 3 || s == 6 || s == 7) return 1'b1;
        nb = 32'd1 << s[1:0];
        return (a % nb) != 0;
    endfunction

    task automatic step();
        bit eg0, eg1, erv, eerr, emreq;
        logic [DW-1:0] erd;
        #4;
        eg0 = 0; eg1 = 0; erv = 0; eerr = 0; erd = '0;
        if (!rst && !outst) begin
            if (bus.m0_req_i && !bus.m1_req_i)      eg0 = 1;
            else if (bus.m1_req_i && !bus.m0_req_i) eg1 = 1;
            else if (bus.m0_req_i && bus.m1_req_i) begin eg0 = !rr; eg1 = rr; end
        end
        emreq = outst && !mis && !accepted;
        if (!rst && outst) begin
            if (mis) begin erv = 1; eerr = 1; end
            else if (accepted && bus.mem_rvalid_i) begin erv = 1; erd = bus.mem_rdata_i; end
        end
        chk("m0_gnt", bus.m0_gnt_o, eg0);
        chk("m1_gnt", bus.m1_gnt_o, eg1);
        chk("m0_rvalid", bus.m0_rvalid_o, erv && !own);
        chk("m1_rvalid", bus.m1_rvalid_o, erv && own);
        chk("m0_err", bus.m0_err_o, eerr && !own);
        chk("m1_err", bus.m1_err_o, eerr && own);
        chk("m0_rdata", bus.m0_rdata_o, own ? 32'h0 : erd);
        chk("m1_rdata", bus.m1_rdata_o, own ? erd : 32'h0);
        chk("mem_req", bus.mem_req_o, emreq);
        if (emreq) begin
            chk("mem_we", bus.mem_we_o, we_m);
            chk("mem_addr", bus.mem_addr_o, addr_m);
            chk("mem_wdata", bus.mem_wdata_o, wdata_m);
            chk("mem_size", bus.mem_size_o, size_m);
        end
        if (bus.m0_gnt_o) gnt_log.push_back(0);
        if (bus.m1_gnt_o) gnt_log.push_back(1);
        obs_rsp += int'(bus.m0_rvalid_o) + int'(bus.m1_rvalid_o);
        last_g0 = eg0;
        last_g1 = eg1;
        if (rst) begin
            outst = 0; accepted = 0; rr = 0; own = 0;
        end else begin
            if (erv) begin outst = 0; rr = !own; end
            else if (emreq && bus.mem_gnt_i) accepted = 1;
            if (eg0 || eg1) begin
                outst = 1; accepted = 0; own = eg1;
                we_m    = eg1 ? bus.m1_we_i    : bus.m0_we_i;
                addr_m  = eg1 ? bus.m1_addr_i  : bus.m0_addr_i;
                wdata_m = eg1 ? bus.m1_wdata_i : bus.m0_wdata_i;
                size_m  = eg1 ? bus.m1_size_i  : bus.m0_size_i;
                mis     = is_mis(size_m, addr_m);
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0; bus.m0_size_i = '0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0; bus.m1_size_i = '0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    endtask

    task automatic set_req(input int m, input logic we, input logic [AW-1:0] a,
                           input logic [SW-1:0] s, input logic [DW-1:0] d);
        if (m == 0) begin
            bus.m0_req_i = 1; bus.m0_we_i = we; bus.m0_addr_i = a; bus.m0_size_i = s; bus.m0_wdata_i = d;
        end else begin
            bus.m1_req_i = 1; bus.m1_we_i = we; bus.m1_addr_i = a; bus.m1_size_i = s; bus.m1_wdata_i = d;
        end
    endtask

    task automatic new_req(input int m);
        logic [SW-1:0] s;
        s = ($urandom_range(3) == 0) ? SW'($urandom_range(7)) : SW'($urandom_range(2));
        set_req(m, 1'($urandom_range(1)), AW'($urandom), s, DW'($urandom));
    endtask

    task automatic drive_mem();
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = DW'($urandom);
        gave_gnt = 0;
        if (pend) begin
            if (dly == 0) begin bus.mem_rvalid_i = 1; pend = 0; end
            else dly--;
        end else if (bus.mem_req_o && $urandom_range(99) < gnt_pct) begin
            bus.mem_gnt_i = 1; gave_gnt = 1;
        end else if ($urandom_range(99) < spur_pct) begin
            bus.mem_rvalid_i = 1;
        end
    endtask

    task automatic end_mem();
        if (rst) pend = 0;
        else if (gave_gnt) begin pend = 1; dly = $urandom_range(max_dly, 0); end
    endtask

    initial begin
        rst = 1; idle_inputs();
        outst = 0; accepted = 0; mis = 0; own = 0; rr = 0;
        we_m = 0; addr_m = '0; wdata_m = '0; size_m = '0;
        pend = 0; gave_gnt = 0; dly = 0; obs_rsp = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        step();
        chk("rst_mem_we", bus.mem_we_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 0);
        chk("rst_mem_size", bus.mem_size_o, 0);
        next();
        rst = 0;

        // m0 word load at 0x100, memory answers at cycle 3
        set_req(0, 0, 32'h100, 3'd2, 32'h0);
        step(); chk("t1_gnt0", bus.m0_gnt_o, 1); chk("t1_gnt1", bus.m1_gnt_o, 0); next();
        bus.m0_req_i = 0; bus.mem_gnt_i = 1;
        step(); chk("t1_memreq", bus.mem_req_o, 1); chk("t1_addr", bus.mem_addr_o, 32'h100); next();
        bus.mem_gnt_i = 0;
        step(); chk("t1_early_rv", bus.m0_rvalid_o, 0); next();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
        step();
        chk("t1_rv", bus.m0_rvalid_o, 1); chk("t1_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
        chk("t1_err", bus.m0_err_o, 0); chk("t1_m1_rv", bus.m1_rvalid_o, 0); chk("t1_m1_rdata", bus.m1_rdata_o, 0);
        next();
        bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;

        // Both request continuously after reset: grants alternate starting at m0
        rst = 1; idle_inputs(); pend = 0;
        step(); next();
        rst = 0;
        set_req(0, 0, 32'h10, 3'd2, 32'h0);
        set_req(1, 1, 32'h20, 3'd2, 32'h0BADF00D);
        gnt_pct = 100; max_dly = 0; spur_pct = 0;
        gnt_log.delete();
        for (int c = 0; c < 14; c++) begin drive_mem(); step(); end_mem(); next(); end
        chk("t2_ngnt", gnt_log.size() >= 4, 1);
        if (gnt_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t2_order%0d", i), gnt_log[i], i % 2);
        bus.m0_req_i = 0; bus.m1_req_i = 0;
        for (int c = 0; c < 6; c++) begin drive_mem(); step(); end_mem(); next(); end
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;

        // Misaligned half store, then illegal size code 3
        set_req(1, 1, 32'h203, 3'd1, 32'h1234);
        step(); chk("t3_gnt1", bus.m1_gnt_o, 1); next();
        bus.m1_req_i = 0;
        step(); chk("t3_rv", bus.m1_rvalid_o, 1); chk("t3_err", bus.m1_err_o, 1); chk("t3_noreq", bus.mem_req_o, 0); next();
        set_req(1, 0, 32'h0, 3'd3, 32'h0);
        step(); chk("t3b_gnt1", bus.m1_gnt_o, 1); next();
        bus.m1_req_i = 0;
        step(); chk("t3b_rv", bus.m1_rvalid_o, 1); chk("t3b_err", bus.m1_err_o, 1); chk("t3b_noreq", bus.mem_req_o, 0); next();

        // mem_gnt_i stalled 5 cycles with m1 waiting and a spurious response
        set_req(0, 0, 32'h40, 3'd2, 32'h0);
        step(); chk("t4_gnt0", bus.m0_gnt_o, 1); next();
        bus.m0_req_i = 0;
        set_req(1, 0, 32'h80, 3'd2, 32'h0);
        for (int k = 0; k < 5; k++) begin
            bus.mem_gnt_i = 0; bus.mem_rvalid_i = (k == 2); bus.mem_rdata_i = 32'h5555AAAA;
            step();
            chk("t4_stall_req", bus.mem_req_o, 1); chk("t4_stall_addr", bus.mem_addr_o, 32'h40);
            chk("t4_no_gnt1", bus.m1_gnt_o, 0); chk("t4_spur", bus.m0_rvalid_o, 0);
            next();
        end
        bus.mem_rvalid_i = 0; bus.mem_gnt_i = 1;
        step(); next();
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h12345678;
        step(); chk("t4_rv", bus.m0_rvalid_o, 1); chk("t4_rdata", bus.m0_rdata_o, 32'h12345678);
        chk("t4_gnt_wait", bus.m1_gnt_o, 0); next();
        bus.mem_rvalid_i = 0;
        step(); chk("t4_gnt1", bus.m1_gnt_o, 1); next();
        bus.m1_req_i = 0;

        // Reset while waiting for the response
        bus.mem_gnt_i = 1;
        step(); next();
        bus.mem_gnt_i = 0; rst = 1;
        step(); next();
        rst = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFEF00D;
        set_req(1, 0, 32'h84, 3'd2, 32'h0);
        step(); chk("t5_memreq", bus.mem_req_o, 0); chk("t5_late_rv", bus.m1_rvalid_o, 0);
        chk("t5_gnt1", bus.m1_gnt_o, 1); next();
        bus.m1_req_i = 0; bus.mem_rvalid_i = 0;
        pend = 0;

        // Randomized traffic with stalls, spurious responses and occasional resets
        gnt_pct = 60; max_dly = 3; spur_pct = 10; obs_rsp = 0;
        for (int c = 0; c < 3000; c++) begin
            if (last_g0 || !bus.m0_req_i) begin
                if ($urandom_range(99) < 40) new_req(0); else bus.m0_req_i = 0;
            end
            if (last_g1 || !bus.m1_req_i) begin
                if ($urandom_range(99) < 40) new_req(1); else bus.m1_req_i = 0;
            end
            rst = ($urandom_range(399) == 0);
            drive_mem(); step(); end_mem(); next();
        end
        rst = 0;
        chk("rand_progress", obs_rsp > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
